clint_timer: RTL and testbench

//  Core-local interruptor: memory-mapped machine timer and software-interrupt source.

---
 rtl/clint_timer_if.sv | 28 ++
 rtl/clint_timer.sv | 114 +++++++++++
 tb/tb_clint_timer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// Bus between the MMIO master and the CLINT: one-cycle access strobe,
// read data returned one cycle later with a valid pulse.
interface clint_timer_if;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_rvalid
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_rvalid
  );
endinterface

// File: rtl/clint_timer.sv
// Single-hart CLINT: msip/mtimecmp/mtime with a prescaled 64-bit timer; reads return
// one cycle after the request, no stall. CLINT_MTIME_WRITE_EN makes MTIME writable.
module clint_timer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  clint_timer_if.slave       bus,
  output logic               msip,
  output logic               mtip,
  output logic [63:0]        mtime_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [15:0] A_MSIP   = 16'h0000;
  localparam logic [15:0] A_CMP_LO = 16'h4000;
  localparam logic [15:0] A_CMP_HI = 16'h4004;
  localparam logic [15:0] A_MT_LO  = 16'hBFF8;
  localparam logic [15:0] A_MT_HI  = 16'hBFFC;

  logic [PW-1:0] presc_q,    presc_d;
  logic [63:0]   mtime_q,    mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q,     msip_d;
  logic          mtip_q,     mtip_d;
  logic [31:0]   rdata_q,    rdata_d;
  logic          rvalid_q,   rvalid_d;

  logic [15:0] addr_m;
  logic        wr, rd, tick;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;

  assign addr_m     = bus.bus_addr & BASE_MASK;
  assign wr         = bus.bus_req &  bus.bus_we;
  assign rd         = bus.bus_req & ~bus.bus_we;
  assign sel_msip   = (addr_m == (A_MSIP   & BASE_MASK));
  assign sel_cmp_lo = (addr_m == (A_CMP_LO & BASE_MASK));
  assign sel_cmp_hi = (addr_m == (A_CMP_HI & BASE_MASK));
  assign sel_mt_lo  = (addr_m == (A_MT_LO  & BASE_MASK));
  assign sel_mt_hi  = (addr_m == (A_MT_HI  & BASE_MASK));
  assign tick       = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
`ifdef CLINT_MTIME_WRITE_EN
    // A software write to MTIME overrides a coincident tick and restarts the prescaler.
    if (wr && sel_mt_lo) begin
      mtime_d = {mtime_q[63:32], bus.bus_wdata};
      presc_d = '0;
    end
    if (wr && sel_mt_hi) begin
      mtime_d = {bus.bus_wdata, mtime_q[31:0]};
      presc_d = '0;
    end
`endif
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata};
    if (wr && sel_cmp_hi) mtimecmp_d = {bus.bus_wdata, mtimecmp_q[31:0]};
  end

  always_comb begin
    msip_d = msip_q;
    if (wr && sel_msip) msip_d = bus.bus_wdata[0];
  end

  // Compare uses the current registers, so mtip trails any change by one cycle.
  assign mtip_d = (mtime_q >= mtimecmp_q);

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd;
    if (rd) begin
      rdata_d = 32'h0;
      if (sel_msip)   rdata_d = {31'h0, msip_q};
      if (sel_cmp_lo) rdata_d = mtimecmp_q[31:0];
      if (sel_cmp_hi) rdata_d = mtimecmp_q[63:32];
      if (sel_mt_lo)  rdata_d = mtime_q[31:0];
      if (sel_mt_hi)  rdata_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.bus_rvalid = rvalid_q;
  assign msip           = msip_q;
  assign mtip           = mtip_q;
  assign mtime_o        = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: a TICK_DIV=4 instance for map/interrupt behaviour and a
// TICK_DIV=1 instance for MTIME writes and wrap; read data checked from a scoreboard.
module tb_clint_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clint_timer_if b4 ();
  clint_timer_if b1 ();

  logic        msip4, mtip4, msip1, mtip1;
  logic [63:0] mtime4, mtime1;

  clint_timer #(.TICK_DIV(4), .BASE_MASK(16'hFFFF)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4), .msip(msip4), .mtip(mtip4), .mtime_o(mtime4));

  clint_timer #(.TICK_DIV(1), .BASE_MASK(16'hFFFF)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .msip(msip1), .mtip(mtip1), .mtime_o(mtime1));

`ifdef CLINT_MTIME_WRITE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] q4[$];
  logic [31:0] q1[$];

  // Edges since reset release; the timers are modelled from this count.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b4.bus_rvalid === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid4_unexpected actual=1 expected=0");
      end else chk("rdata4", 64'(b4.bus_rdata), 64'(q4.pop_front()));
    end
    if (b1.bus_rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid1_unexpected actual=1 expected=0");
      end else chk("rdata1", 64'(b1.bus_rdata), 64'(q1.pop_front()));
    end
  end

  task automatic idle_bus();
    b4.bus_req = 1'b0; b4.bus_we = 1'b0; b4.bus_addr = '0; b4.bus_wdata = '0;
    b1.bus_req = 1'b0; b1.bus_we = 1'b0; b1.bus_addr = '0; b1.bus_wdata = '0;
  endtask

  // Called just after a rising edge; returns just after the access edge.
  task automatic access(input bit s, input bit we, input logic [15:0] a, input logic [31:0] d);
    if (s) begin
      b1.bus_req = 1'b1; b1.bus_we = we; b1.bus_addr = a; b1.bus_wdata = d;
    end else begin
      b4.bus_req = 1'b1; b4.bus_we = we; b4.bus_addr = a; b4.bus_wdata = d;
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_wr(input bit s, input logic [15:0] a, input logic [31:0] d);
    access(s, 1'b1, a, d);
  endtask

  task automatic bus_rd(input bit s, input logic [15:0] a, input logic [31:0] exp);
    if (s) q1.push_back(exp);
    else   q4.push_back(exp);
    access(s, 1'b0, a, 32'h0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_msip",   64'(msip4), 64'd0);
    chk("rst_mtip",   64'(mtip4), 64'd0);
    chk("rst_mtime",  mtime4, 64'd0);
    chk("rst_rvalid", 64'(b4.bus_rvalid), 64'd0);
    chk("rst_rdata",  64'(b4.bus_rdata), 64'd0);
    rst = 1'b0;

    // Reset compare value, then the rvalid pulse shape.
    bus_rd(1'b0, 16'h4000, 32'hFFFF_FFFF);
    chk("rvalid_hi", 64'(b4.bus_rvalid), 64'd1);
    step();
    chk("rvalid_pulse", 64'(b4.bus_rvalid), 64'd0);
    bus_rd(1'b0, 16'h4004, 32'hFFFF_FFFF);

    wait_cyc(40);
    chk("mtime_40cyc", mtime4, 64'd10);
    // Request edge lands on a tick: read returns the pre-tick count.
    wait_cyc(43);
    bus_rd(1'b0, 16'hBFF8, 32'd10);
    chk("mtime_post_tick", mtime4, 64'd11);
    bus_rd(1'b0, 16'hBFFC, 32'd0);

    bus_wr(1'b0, 16'h4000, 32'd20);
    bus_wr(1'b0, 16'h4004, 32'd0);
    bus_rd(1'b0, 16'h4000, 32'd20);
    bus_rd(1'b0, 16'h4004, 32'd0);

    wait_cyc(80);
    chk("mtime_20", mtime4, 64'd20);
    chk("mtip_lag", 64'(mtip4), 64'd0);
    step();
    chk("mtip_set", 64'(mtip4), 64'd1);
    bus_wr(1'b0, 16'h4000, 32'hFFFF_FFFF);
    chk("mtip_hold_write_edge", 64'(mtip4), 64'd1);
    step();
    chk("mtip_clear", 64'(mtip4), 64'd0);

    chk("msip_before", 64'(msip4), 64'd0);
    bus_wr(1'b0, 16'h0000, 32'hFFFF_FFFF);
    chk("msip_set", 64'(msip4), 64'd1);
    bus_rd(1'b0, 16'h0000, 32'h0000_0001);
    bus_wr(1'b0, 16'h0000, 32'h0);
    chk("msip_clear", 64'(msip4), 64'd0);
    bus_rd(1'b0, 16'h1234, 32'h0);
    bus_wr(1'b0, 16'h1234, 32'hDEAD_BEEF);
    bus_rd(1'b0, 16'h1234, 32'h0);

    // MTIME write and wrap on the undivided instance.
    bus_wr(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    bus_wr(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    e = FEAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(cyc);
    chk("mtime1_after_write", mtime1, e);
    bus_rd(1'b1, 16'hBFF8, e[31:0]);
    e = FEAT ? 64'h0 : 64'(cyc);
    chk("mtime1_wrap", mtime1, e);
    bus_rd(1'b1, 16'hBFFC, e[63:32]);
    step();
    step();

    // Reset during a read request: the response must never appear.
    b4.bus_req = 1'b1; b4.bus_we = 1'b0; b4.bus_addr = 16'h1234;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    chk("midrst_rvalid", 64'(b4.bus_rvalid), 64'd0);
    chk("midrst_mtime",  mtime4, 64'd0);
    chk("midrst_mtip",   64'(mtip4), 64'd0);
    step();
    chk("midrst_rvalid2", 64'(b4.bus_rvalid), 64'd0);
    rst = 1'b0;
    bus_rd(1'b0, 16'h4000, 32'hFFFF_FFFF);
    step();
    step();

    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
